timer_periph: RTL
=================

Name: timer_periph

Overview:
Memory-mapped down-counting timer at TIMER_BASE_ADDR (0x4000_0000). It is the interrupt source for the CPU core.
- Raises `interrupt` on expiry.
- Holds it until the ISR writes 1 to the INT_CLR register at base+4.
- Sits directly upstream of the core's interrupt input and on the shared CPU memory bus (addr / data / write_enable / read_enable).

Parameters:
- BASE_ADDR, 32'h4000_0000, byte address of register block; decode on addr[31:8]==BASE_ADDR[31:8].
- PRESCALE_W, 8, width of PRESCALE register and prescale counter.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- addr  in  32  CPU bus address
- wdata  in  32  CPU write data (core data_out)
- rdata  out  32  registered read data (to core data_in)
- write_enable  in  1  write strobe, sampled each rising edge
- read_enable  in  1  read strobe, sampled each rising edge
- interrupt  out  1  level interrupt to core = irq_flag & CTRL.IRQ_EN

Behaviour:
- Register map (offset from base, word aligned, addr[1:0] ignored):
  - 0x00 CTRL RW: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN; other bits read 0.
  - 0x04 INT_CLR WO: writing bit0=1 clears irq_flag; reads 0.
  - 0x08 LOAD RW: 32-bit reload value.
  - 0x0C VALUE RO: current count; writes ignored.
  - 0x10 PRESCALE RW: [PRESCALE_W-1:0]; tick every PRESCALE+1 cycles.
  - 0x14 STATUS RO: bit0 irq_flag (raw, independent of IRQ_EN).
  - Unmapped offsets: read 0, writes ignored. Accesses outside the block are ignored and rdata is forced to 0.
- Reset values: CTRL=0, LOAD=0, VALUE=0, PRESCALE=0, prescale counter=0, irq_flag=0, rdata=0, interrupt=0, state=IDLE.
- Read latency: read_enable sampled at edge k, rdata valid after edge k; rdata returns to 0 on the next edge without read_enable.
- Write: takes effect at the edge where write_enable=1.
- FSM states: IDLE, RUN, EXPIRED.
  - IDLE: write CTRL with EN=1 -> VALUE<=LOAD, prescale cnt<=0, go RUN.
  - RUN: tick when prescale cnt==PRESCALE, then cnt<=0; otherwise cnt+1.
    - On tick with VALUE!=0: VALUE-1.
    - On tick with VALUE==0: irq_flag<=1. If AUTO_RELOAD: VALUE<=LOAD, stay RUN. Else CTRL.EN<=0, go EXPIRED.
  - RUN, write CTRL EN=0: go IDLE, VALUE holds.
  - EXPIRED: VALUE holds 0. Write CTRL with EN=1 reloads and goes RUN, same as from IDLE.
- Expiry timing: first irq_flag after (LOAD+1)*(PRESCALE+1) edges from the enabling write.
- LOAD written during RUN: used at next reload only.
- LOAD=0 with AUTO_RELOAD: flag set on every tick.
- Simultaneous INT_CLR write and expiry in the same cycle: set wins, flag stays 1.
- Write CTRL with EN=1 while already in RUN: no restart; other bits update.
- interrupt is combinational AND of two flops, with no extra latency. Clearing IRQ_EN masks the output but does not clear irq_flag.
- Reset asserted mid-count: all state returns to reset values the next edge; no pending interrupt survives.
- read_enable and write_enable both high: write performed, read data returned from pre-write value.

Optional Feature:
- Macro TIMER_MISSED_CNT_EN.
- Defined: adds 0x18 MISSED RO, 8 bits.
  - Increments, saturating at 255, on each expiry while irq_flag is already 1.
  - Cleared by any INT_CLR write with bit0=1. If that write coincides with an expiry, MISSED <= 0 and flag stays 1.
- Not defined: offset 0x18 is unmapped and reads 0; no counter logic.

Decomposition:
- Package timer_pkg:
  - register offset constants (OFF_CTRL .. OFF_MISSED);
  - CTRL bit indices (CTRL_EN, CTRL_AUTO, CTRL_IRQEN);
  - FSM state typedef (IDLE/RUN/EXPIRED);
  - TIMER_BASE_ADDR default.
- Sub-module timer_prescaler:
  - inputs: clk, reset, clear, enable, prescale;
  - output: one-cycle tick pulse.
  - Reused later by other peripherals.

Test Plan:
- Reset, read every offset -> all 0, interrupt=0; reads from an address outside the block return 0.
- LOAD=3, PRESCALE=1, CTRL=0x5 (EN, IRQ_EN, one-shot):
  - interrupt rises 8 edges after CTRL write;
  - CTRL reads 0x4, VALUE=0, STATUS=1.
- Write INT_CLR=1 -> interrupt=0 next edge. Then CTRL=0x7, LOAD=2, PRESCALE=0:
  - interrupt every 3 cycles once cleared each time;
  - VALUE read sequence 2,1,0,2.
- INT_CLR write on the exact expiry edge -> STATUS stays 1, interrupt stays 1. With TIMER_MISSED_CNT_EN, let 3 expiries pass uncleared -> MISSED=2.
- Mid-count CTRL=0x4 (EN=0) with VALUE=5 -> VALUE holds 5 for 10 cycles, no interrupt. Then assert reset 1 cycle -> all registers 0.
- IRQ_EN=0 with expiry -> STATUS=1, interrupt=0. Set IRQ_EN -> interrupt=1 next edge.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants and types for the memory-mapped down-counting timer.
package timer_pkg;

  localparam logic [31:0] TIMER_BASE_ADDR = 32'h4000_0000;

  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_INT_CLR  = 8'h04;
  localparam logic [7:0] OFF_LOAD     = 8'h08;
  localparam logic [7:0] OFF_VALUE    = 8'h0C;
  localparam logic [7:0] OFF_PRESCALE = 8'h10;
  localparam logic [7:0] OFF_STATUS   = 8'h14;
  localparam logic [7:0] OFF_MISSED   = 8'h18;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_AUTO  = 1;
  localparam int CTRL_IRQEN = 2;
  localparam int CTRL_W     = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } timer_state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Programmable prescaler: emits a one-cycle tick every prescale+1 enabled cycles.
module timer_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  localparam logic [PRESCALE_W-1:0] CNT_ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] cnt_r;

  assign tick = enable && (cnt_r == prescale);

  // Prescale counter: wraps to zero on each tick, restarts on clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (tick) begin
      cnt_r <= '0;
    end else if (enable) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/timer_periph.sv
// Memory-mapped down-counting timer with a level interrupt held until INT_CLR.
// Define TIMER_MISSED_CNT_EN to add the saturating MISSED expiry counter at 0x18.
module timer_periph
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = TIMER_BASE_ADDR,
  parameter int          PRESCALE_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        write_enable,
  input  logic        read_enable,
  output logic        interrupt
);

  logic                  hit_s;
  logic                  wr_s;
  logic                  rd_s;
  logic [7:0]            off_s;
  logic                  ctrl_wr_s;
  logic                  clr_wr_s;
  logic                  load_wr_s;
  logic                  pre_wr_s;
  logic                  unused_s;

  timer_state_e          state_r;
  timer_state_e          state_next_s;
  logic                  running_s;
  logic                  start_s;
  logic                  stop_s;
  logic                  tick_s;
  logic                  count_s;
  logic                  expire_s;
  logic                  oneshot_done_s;

  logic [CTRL_W-1:0]     ctrl_r;
  logic [31:0]           load_r;
  logic [31:0]           value_r;
  logic [PRESCALE_W-1:0] prescale_r;
  logic                  irq_flag_r;
  logic [31:0]           rdata_s;

  assign hit_s     = (addr[31:8] == BASE_ADDR[31:8]);
  assign off_s     = {addr[7:2], 2'b00};
  assign wr_s      = write_enable && hit_s;
  assign rd_s      = read_enable && hit_s;
  assign ctrl_wr_s = wr_s && (off_s == OFF_CTRL);
  assign clr_wr_s  = wr_s && (off_s == OFF_INT_CLR) && wdata[0];
  assign load_wr_s = wr_s && (off_s == OFF_LOAD);
  assign pre_wr_s  = wr_s && (off_s == OFF_PRESCALE);
  assign unused_s  = ^addr[1:0];

  timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .clear    (start_s),
    .enable   (running_s),
    .prescale (prescale_r),
    .tick     (tick_s)
  );

  // A stop write in the same cycle freezes the count, so no tick acts on VALUE.
  assign count_s        = tick_s && !stop_s;
  assign expire_s       = count_s && (value_r == 32'd0);
  assign oneshot_done_s = expire_s && !ctrl_r[CTRL_AUTO];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE, EXPIRED: begin
        if (start_s) begin
          state_next_s = RUN;
        end else begin
          state_next_s = state_r;
        end
      end
      RUN: begin
        if (stop_s) begin
          state_next_s = IDLE;
        end else if (oneshot_done_s) begin
          state_next_s = EXPIRED;
        end else begin
          state_next_s = RUN;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM outputs: EN writes start from IDLE/EXPIRED, EN=0 writes stop a run.
  always_comb begin
    running_s = 1'b0;
    start_s   = 1'b0;
    stop_s    = 1'b0;
    case (state_r)
      IDLE, EXPIRED: start_s = ctrl_wr_s && wdata[CTRL_EN];
      RUN: begin
        running_s = 1'b1;
        stop_s    = ctrl_wr_s && !wdata[CTRL_EN];
      end
      default: begin
        running_s = 1'b0;
        start_s   = 1'b0;
        stop_s    = 1'b0;
      end
    endcase
  end

  // CTRL register; a one-shot expiry drops EN even against a concurrent write.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_r <= 3'b000;
    end else if (ctrl_wr_s) begin
      ctrl_r <= {wdata[CTRL_IRQEN], wdata[CTRL_AUTO], wdata[CTRL_EN] && !oneshot_done_s};
    end else if (oneshot_done_s) begin
      ctrl_r <= ctrl_r & 3'b110;
    end else begin
      ctrl_r <= ctrl_r;
    end
  end

  // LOAD and PRESCALE configuration registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_r     <= 32'd0;
      prescale_r <= '0;
    end else begin
      load_r     <= load_wr_s ? wdata : load_r;
      prescale_r <= pre_wr_s ? wdata[PRESCALE_W-1:0] : prescale_r;
    end
  end

  // Down counter; reload uses LOAD as it stood before any same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_r <= 32'd0;
    end else if (start_s) begin
      value_r <= load_r;
    end else if (count_s) begin
      if (value_r != 32'd0) begin
        value_r <= value_r - 32'd1;
      end else if (ctrl_r[CTRL_AUTO]) begin
        value_r <= load_r;
      end else begin
        value_r <= value_r;
      end
    end else begin
      value_r <= value_r;
    end
  end

  // Sticky expiry flag; a new expiry wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_flag_r <= 1'b0;
    end else if (expire_s) begin
      irq_flag_r <= 1'b1;
    end else if (clr_wr_s) begin
      irq_flag_r <= 1'b0;
    end else begin
      irq_flag_r <= irq_flag_r;
    end
  end

`ifdef TIMER_MISSED_CNT_EN
  logic [7:0] missed_r;

  // Counts expiries that land on an already-pending flag, saturating at 255.
  always_ff @(posedge clk) begin
    if (reset) begin
      missed_r <= 8'd0;
    end else if (clr_wr_s) begin
      missed_r <= 8'd0;
    end else if (expire_s && irq_flag_r && (missed_r != 8'hFF)) begin
      missed_r <= missed_r + 8'd1;
    end else begin
      missed_r <= missed_r;
    end
  end
`endif

  // Read mux over pre-write register values.
  always_comb begin
    rdata_s = 32'd0;
    if (rd_s) begin
      case (off_s)
        OFF_CTRL:     rdata_s = 32'(ctrl_r);
        OFF_LOAD:     rdata_s = load_r;
        OFF_VALUE:    rdata_s = value_r;
        OFF_PRESCALE: rdata_s = 32'(prescale_r);
        OFF_STATUS:   rdata_s = {31'd0, irq_flag_r};
`ifdef TIMER_MISSED_CNT_EN
        OFF_MISSED:   rdata_s = {24'd0, missed_r};
`endif
        default:      rdata_s = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  // Registered read data, zero whenever no in-block read was sampled.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= 32'd0;
    end else begin
      rdata <= rdata_s;
    end
  end

  assign interrupt = irq_flag_r && ctrl_r[CTRL_IRQEN];

endmodule
